// File: rtl/rtc_vga_pkg.sv
// +----------------------------------------------------------------------------+
// | rtc_vga_pkg: shared types and constants for the RTC-to-VGA frame loader.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package rtc_vga_pkg;

    localparam int DATA_W   = 8;
    localparam int COORD_W  = 10;
    localparam int NREG_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GAP     = 2'd2,
        ST_PUBLISH = 2'd3
    } fetch_state_t;

    // RTC register addresses in display order: hour, date, timer (sec/min/hr style)
    localparam logic [DATA_W-1:0] ADDR_MAP [NREG_DEF] = '{
        8'h21, 8'h22, 8'h23,
        8'h24, 8'h25, 8'h26,
        8'h41, 8'h42, 8'h43
    };

endpackage

`default_nettype wire

// File: rtl/vga_frame_shadow.sv
// +----------------------------------------------------------------------------+
// | vga_frame_shadow: shadow byte file with indexed write and bulk publish.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_frame_shadow
    import rtc_vga_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              publish,
    output logic [DATA_W-1:0] pub_data [NREG]
);

    logic [DATA_W-1:0] shadow [NREG];

    // Publish reads the shadow as it stood before this edge, so all bytes move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i]   <= '0;
                pub_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (clear) begin
                    shadow[i] <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                    shadow[i] <= wr_data;
                end
                if (publish) begin
                    pub_data[i] <= shadow[i];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_frame_loader.sv
// +----------------------------------------------------------------------------+
// | vga_frame_loader: once-per-frame RTC fetch with tear-free publish.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_frame_loader
    import rtc_vga_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int VBL_LINE = 480,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               freeze,
    output logic               rd_req,
    output logic [DATA_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  hour_out1,
    output logic [DATA_W-1:0]  hour_out2,
    output logic [DATA_W-1:0]  hour_out3,
    output logic [DATA_W-1:0]  fecha_out1,
    output logic [DATA_W-1:0]  fecha_out2,
    output logic [DATA_W-1:0]  fecha_out3,
    output logic [DATA_W-1:0]  timer_out1,
    output logic [DATA_W-1:0]  timer_out2,
    output logic [DATA_W-1:0]  timer_out3,
    output logic               frame_valid,
    output logic               busy,
    output logic               rd_error
);

    localparam int IDX_W  = $clog2(NREG);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t       state;
    logic [IDX_W-1:0]   idx;
    logic [TCNT_W-1:0]  tcnt;
    logic               vbl_hit;
    logic               vbl_prev;
    logic               trigger;
    logic               capture;
    logic               abort;
    logic               publish;
    logic [DATA_W-1:0]  pub_data [NREG];

    assign trigger = vbl_hit && !vbl_prev;
    assign capture = (state == ST_REQ) && rd_ack;
    assign abort   = (state == ST_REQ) && !rd_ack && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign publish = (state == ST_PUBLISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vbl_hit     <= 1'b0;
            vbl_prev    <= 1'b0;
            state       <= ST_IDLE;
            idx         <= '0;
            tcnt        <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            vbl_hit     <= (pixel_y == COORD_W'(VBL_LINE));
            vbl_prev    <= vbl_hit;
            frame_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger && !freeze) begin
                        state   <= ST_REQ;
                        busy    <= 1'b1;
                        idx     <= '0;
                        tcnt    <= '0;
                        rd_req  <= 1'b1;
                        rd_addr <= ADDR_MAP[0];
                    end
                end
                ST_REQ: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        tcnt   <= '0;
                        if (idx == IDX_W'(NREG - 1)) begin
                            state <= ST_PUBLISH;
                        end else begin
                            state <= ST_GAP;
                            idx   <= idx + IDX_W'(1);
                        end
                    end else if (abort) begin
                        // Shadow is wiped by the same condition; outputs keep last frame.
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        rd_req   <= 1'b0;
                        rd_error <= 1'b1;
                        idx      <= '0;
                        tcnt     <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                ST_GAP: begin
                    state   <= ST_REQ;
                    rd_req  <= 1'b1;
                    rd_addr <= ADDR_MAP[idx];
                    tcnt    <= '0;
                end
                ST_PUBLISH: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    frame_valid <= 1'b1;
                    rd_error    <= 1'b0;
                    idx         <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

    vga_frame_shadow #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .clear    (abort),
        .wr_en    (capture),
        .wr_idx   (idx),
        .wr_data  (rd_data),
        .publish  (publish),
        .pub_data (pub_data)
    );

    assign hour_out1  = pub_data[0];
    assign hour_out2  = pub_data[1];
    assign hour_out3  = pub_data[2];
    assign fecha_out1 = pub_data[3];
    assign fecha_out2 = pub_data[4];
    assign fecha_out3 = pub_data[5];
    assign timer_out1 = pub_data[6];
    assign timer_out2 = pub_data[7];
    assign timer_out3 = pub_data[8];

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_loader.sv
// +----------------------------------------------------------------------------+
// | tb_vga_frame_loader: scoreboard bench for the per-frame RTC fetch.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_frame_loader;

    logic       clk;
    logic       reset;
    logic [9:0] pixel_y;
    logic       freeze;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [7:0] hour_out1, hour_out2, hour_out3;
    logic [7:0] fecha_out1, fecha_out2, fecha_out3;
    logic [7:0] timer_out1, timer_out2, timer_out3;
    logic       frame_valid;
    logic       busy;
    logic       rd_error;

    vga_frame_loader dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_y     (pixel_y),
        .freeze      (freeze),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .hour_out1   (hour_out1),
        .hour_out2   (hour_out2),
        .hour_out3   (hour_out3),
        .fecha_out1  (fecha_out1),
        .fecha_out2  (fecha_out2),
        .fecha_out3  (fecha_out3),
        .timer_out1  (timer_out1),
        .timer_out2  (timer_out2),
        .timer_out3  (timer_out3),
        .frame_valid (frame_valid),
        .busy        (busy),
        .rd_error    (rd_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  amap [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0]  addr_q [$];
    logic [71:0] exp_q [$];
    logic [71:0] last_pub = '0;
    logic [7:0]  pend [9];
    logic [7:0]  data_off = 8'h01;
    int          acks_in_frame = 0;
    int          withhold_idx  = 99;
    int          stall_cnt     = 0;
    int          ack_total     = 0;
    int          req_cycles    = 0;
    int          fv_cnt        = 0;
    int          busy_run      = 0;
    int          last_busy_len = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] outs();
        return {hour_out1, hour_out2, hour_out3, fecha_out1, fecha_out2, fecha_out3,
                timer_out1, timer_out2, timer_out3};
    endfunction

    // RTC responder: acks in the same cycle it sees rd_req, data = address + data_off.
    initial begin
        logic [7:0]  exp_a;
        logic [71:0] f;
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0;
            if (reset && rd_req) begin
                req_cycles++;
                if (acks_in_frame == withhold_idx) begin
                    stall_cnt++;
                end else begin
                    chk("req_expected", 72'(addr_q.size() != 0), 72'(1));
                    exp_a = rd_addr;
                    if (addr_q.size() != 0) begin
                        exp_a = addr_q.pop_front();
                        chk("rd_addr", 72'(rd_addr), 72'(exp_a));
                    end
                    rd_ack  = 1'b1;
                    rd_data = exp_a + data_off;
                    pend[acks_in_frame] = rd_data;
                    acks_in_frame++;
                    ack_total++;
                    if (acks_in_frame == 9) begin
                        f = '0;
                        for (int i = 0; i < 9; i++) f = {f[63:0], pend[i]};
                        exp_q.push_back(f);
                        acks_in_frame = 0;
                    end
                end
            end
        end
    end

    // Output monitor: outputs may only move on a frame_valid cycle, and then to the scoreboard value.
    initial begin
        logic [71:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_run = 0;
            end else begin
                if (frame_valid) begin
                    fv_cnt++;
                    chk("publish_expected", 72'(exp_q.size() != 0), 72'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("publish", outs(), e);
                        last_pub = outs();
                    end
                end else if (busy) begin
                    chk("hold", outs(), last_pub);
                end
                if (busy) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    last_busy_len = busy_run;
                    busy_run = 0;
                end
            end
        end
    end

    task automatic start_vbl(input int hold, input bit expect_fetch);
        if (expect_fetch) begin
            for (int i = 0; i < 9; i++) addr_q.push_back(amap[i]);
        end
        @(negedge clk);
        pixel_y = 10'd480;
        repeat (hold) @(negedge clk);
        pixel_y = 10'd481;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 72'(busy), 72'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!(acks_in_frame >= n && rd_req) && c < budget);
        chk("wait_acks", 72'(acks_in_frame >= n && rd_req), 72'(1));
    endtask

    initial begin
        int fv0, rq0, ak0;
        reset   = 1'b0;
        pixel_y = 10'd0;
        freeze  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_outs", outs(), 72'(0));
        chk("rst_req", 72'(rd_req), 72'(0));
        chk("rst_addr", 72'(rd_addr), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_fv", 72'(frame_valid), 72'(0));
        chk("rst_err", 72'(rd_error), 72'(0));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_req", 72'(req_cycles), 72'(0));

        // Nominal: every read takes REQ+GAP except the last, plus the PUBLISH cycle.
        fv0 = fv_cnt;
        data_off = 8'h01;
        start_vbl(2, 1'b1);
        wait_idle(200);
        chk("nom_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("nom_busy_len", 72'(last_busy_len), 72'(2 * 9));
        chk("nom_hour1", 72'(hour_out1), 72'(8'h22));
        chk("nom_fecha2", 72'(fecha_out2), 72'(8'h26));
        chk("nom_timer3", 72'(timer_out3), 72'(8'h44));
        chk("nom_err", 72'(rd_error), 72'(0));

        // Atomic publish with data changing mid-fetch.
        fv0 = fv_cnt;
        data_off = 8'h10;
        start_vbl(2, 1'b1);
        wait_acks(4, 100);
        data_off = 8'h30;
        wait_idle(200);
        chk("atom_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("atom_hour1", 72'(hour_out1), 72'(8'h31));
        chk("atom_timer3", 72'(timer_out3), 72'(8'h73));

        // Freeze at the trigger blocks the fetch.
        fv0 = fv_cnt;
        rq0 = req_cycles;
        freeze = 1'b1;
        start_vbl(3, 1'b0);
        repeat (40) @(negedge clk);
        chk("frz_req", 72'(req_cycles - rq0), 72'(0));
        chk("frz_fv", 72'(fv_cnt - fv0), 72'(0));
        freeze = 1'b0;

        // Freeze rising mid-fetch does not stop it.
        data_off = 8'h02;
        start_vbl(2, 1'b1);
        wait_acks(5, 100);
        freeze = 1'b1;
        wait_idle(200);
        chk("frz_mid_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("frz_mid_hour2", 72'(hour_out2), 72'(8'h24));
        freeze = 1'b0;

        // Timeout at index 4.
        fv0 = fv_cnt;
        stall_cnt = 0;
        withhold_idx = 4;
        data_off = 8'h50;
        start_vbl(2, 1'b1);
        wait_idle(600);
        chk("to_stall", 72'(stall_cnt), 72'(255));
        chk("to_err", 72'(rd_error), 72'(1));
        chk("to_req", 72'(rd_req), 72'(0));
        chk("to_fv", 72'(fv_cnt - fv0), 72'(0));
        chk("to_outs", outs(), last_pub);
        addr_q.delete();
        acks_in_frame = 0;
        withhold_idx = 99;
        data_off = 8'h03;
        start_vbl(2, 1'b1);
        wait_idle(200);
        chk("to_recover_err", 72'(rd_error), 72'(0));
        chk("to_recover_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("to_recover_hour1", 72'(hour_out1), 72'(8'h24));

        // Retrigger: long hold, then revisit 480 while busy.
        fv0 = fv_cnt;
        ak0 = ack_total;
        data_off = 8'h04;
        start_vbl(6, 1'b1);
        repeat (2) @(negedge clk);
        chk("retrig_busy", 72'(busy), 72'(1));
        pixel_y = 10'd480;
        repeat (2) @(negedge clk);
        pixel_y = 10'd481;
        wait_idle(200);
        repeat (30) @(negedge clk);
        chk("retrig_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("retrig_acks", 72'(ack_total - ak0), 72'(9));

        // Reset during index 5: rd_req drops without waiting for a clock edge.
        data_off = 8'h05;
        start_vbl(2, 1'b1);
        wait_acks(5, 100);
        chk("rst_mid_req_before", 72'(rd_req), 72'(1));
        reset = 1'b0;
        #1;
        chk("rst_mid_req", 72'(rd_req), 72'(0));
        chk("rst_mid_busy", 72'(busy), 72'(0));
        chk("rst_mid_outs", outs(), 72'(0));
        addr_q.delete();
        exp_q.delete();
        acks_in_frame = 0;
        last_pub = '0;
        pixel_y = 10'd100;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rq0 = req_cycles;
        repeat (40) @(negedge clk);
        chk("rst_mid_noreq", 72'(req_cycles - rq0), 72'(0));
        chk("rst_mid_outs_after", outs(), 72'(0));
        fv0 = fv_cnt;
        data_off = 8'h06;
        start_vbl(2, 1'b1);
        wait_idle(200);
        chk("rst_recover_fv", 72'(fv_cnt - fv0), 72'(1));
        chk("rst_recover_timer1", 72'(timer_out1), 72'(8'h47));
        chk("end_addrq", 72'(addr_q.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
